// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : sequential N-bit ALU with valid/ready request handshake.
//
// Logic, add and subtract finish in one cycle. Shifts move one bit position
// per clock. The optional multiplier is shift-add and handles one multiplier
// bit per clock. Every result passes through an output register stage, so
// out_valid pulses one cycle after the result is known.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : opcode 1010 is an unsigned multiply. It uses the MUL state and
//               a shift-add datapath.
//   undefined : there is no multiplier, and 1010 is treated as A+B.
//
// Ports
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous active-high reset
//   in_valid       in   operation request
//   in_ready       out  high only in IDLE; accept = in_valid & in_ready
//   A, B           in   N-bit operands, sampled at acceptance
//   ALUControl     in   4-bit opcode, sampled at acceptance
//   out_valid      out  one-cycle pulse marking a new result
//   Y              out  registered result, held until the next result
//   negativo, cero, acarreo, desbordamiento
//                  out  registered flags, held together with Y
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  output logic [N-1:0] Y,
  output logic         negativo,
  output logic         cero,
  output logic         acarreo,
  output logic         desbordamiento
);

  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;   // wide enough to count N multiply iterations

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t        state_q, state_d;
  logic [N-1:0]  res_q, res_d;       // result, and the shift working value
  logic [1:0]    sh_mode_q, sh_mode_d; // {arithmetic, right} for the shift in flight
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pc_q, pc_d;         // pending carry/borrow/shift-out flag
  logic          pn_q, pn_d;         // pending negative flag
  logic          pv_q, pv_d;         // pending overflow flag
  logic          emit_q, emit_d;     // result is ready for the output stage

`ifdef ALU_SEQ_MUL_EN
  logic [N-1:0]  hi_q, hi_d;         // upper product half; res_q holds the lower half
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N:0]    mul_sum;
`endif

  logic [N-1:0]  y_q;
  logic          out_valid_q, neg_q, zero_q, carry_q, ovf_q;

  logic [N:0]    add_full, sub_full;
  logic [SW-1:0] shamt;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} - {1'b0, B};   // MSB set means A < B unsigned
  assign shamt    = B[SW-1:0];
  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    sh_mode_d = sh_mode_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    pn_d      = pn_q;
    pv_d      = pv_q;
    emit_d    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    hi_d      = hi_q;
    mcand_d   = mcand_q;
    mul_sum   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pc_d   = 1'b0;
          pn_d   = 1'b0;
          pv_d   = 1'b0;
          emit_d = 1'b1;
          case (ALUControl)
            4'b0000: res_d = A & B;
            4'b0001: res_d = A | B;
            4'b0010: res_d = ~A;
            4'b0011: res_d = A ^ B;
            4'b0101: begin
              res_d = sub_full[N-1:0];
              pc_d  = sub_full[N];
              pn_d  = sub_full[N-1];
              pv_d  = (A[N-1] != B[N-1]) && (sub_full[N-1] != A[N-1]);
            end
            4'b0110, 4'b0111, 4'b1000, 4'b1001: begin
              res_d     = A;
              sh_mode_d = {ALUControl[3], ALUControl[0]};
              // A zero shift amount is a plain pass-through with no shift-out bit.
              if (shamt != '0) begin
                state_d = SHIFT;
                cnt_d   = CW'(shamt);
                emit_d  = 1'b0;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            4'b1010: begin
              res_d   = B;
              hi_d    = '0;
              mcand_d = A;
              cnt_d   = CW'(N);
              state_d = MUL;
              emit_d  = 1'b0;
            end
`endif
            default: begin
              // Covers 0100 and every otherwise unassigned opcode.
              res_d = add_full[N-1:0];
              pc_d  = add_full[N];
              pn_d  = add_full[N-1];
              pv_d  = (A[N-1] == B[N-1]) && (add_full[N-1] != A[N-1]);
            end
          endcase
        end
      end
      SHIFT: begin
        if (sh_mode_q[0]) begin
          pc_d  = res_q[0];
          res_d = {sh_mode_q[1] & res_q[N-1], res_q[N-1:1]};
        end else begin
          pc_d  = res_q[N-1];
          res_d = {res_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          emit_d  = 1'b1;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        // Add the multiplicand when the current multiplier bit is set. Then
        // shift {carry, hi, lo} right by one. The lower half gradually turns
        // into the low product bits.
        mul_sum = {1'b0, hi_q} + (res_q[0] ? {1'b0, mcand_q} : '0);
        hi_d    = mul_sum[N:1];
        res_d   = {mul_sum[0], res_q[N-1:1]};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          emit_d  = 1'b1;
          pc_d    = |mul_sum[N:1];
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      sh_mode_q   <= '0;
      cnt_q       <= '0;
      pc_q        <= 1'b0;
      pn_q        <= 1'b0;
      pv_q        <= 1'b0;
      emit_q      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi_q        <= '0;
      mcand_q     <= '0;
`endif
      y_q         <= '0;
      out_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      sh_mode_q   <= sh_mode_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      pn_q        <= pn_d;
      pv_q        <= pv_d;
      emit_q      <= emit_d;
`ifdef ALU_SEQ_MUL_EN
      hi_q        <= hi_d;
      mcand_q     <= mcand_d;
`endif
      out_valid_q <= emit_q;
      if (emit_q) begin
        y_q     <= res_q;
        zero_q  <= (res_q == '0);
        neg_q   <= pn_q;
        carry_q <= pc_q;
        ovf_q   <= pv_q;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign Y              = y_q;
  assign negativo       = neg_q;
  assign cero           = zero_q;
  assign acarreo        = carry_q;
  assign desbordamiento = ovf_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter N, default 8, operand/result width; legal range 4..32.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset is asynchronous and active-high.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  high only in IDLE; request accepted on edge where in_valid&in_ready.
REQ-006 A, B  input  N each  operands, sampled at acceptance.
REQ-007 ALUControl  input  4  opcode, sampled at acceptance.
REQ-008 out_valid  output  1  one-cycle pulse marking new result.
REQ-009 Y  output  N  registered result, held until next result.
REQ-010 negativo, cero, acarreo, desbordamiento  output  1 each  registered flags, held with Y.

Function
REQ-011 Opcodes: 0000 AND, 0001 OR, 0010 NOT A, 0011 XOR, 0100 A+B, 0101 A-B, 0110 logical left shift, 0111 logical right shift, 1000 arithmetic left shift, 1001 arithmetic right shift (sign fill), 1010 unsigned multiply, 1011-1111 treated as A+B.
REQ-012 States IDLE, SHIFT, MUL; IDLE->SHIFT on accepted shift with shamt!=0; IDLE->MUL on accepted multiply; SHIFT/MUL->IDLE on final iteration.
REQ-013 Shift amount shamt = B[$clog2(N)-1:0]; one bit position per clock in SHIFT.
REQ-014 Latency (acceptance edge to out_valid-high cycle start): 1 cycle for logic/add/sub, and for shifts with shamt=0; 1+shamt for shifts; N+1 for multiply.
REQ-015 Multiply: shift-add, one multiplier bit per cycle; Y = low N bits of product.
REQ-016 Requests with in_valid high while in_ready low are ignored, not queued.
REQ-017 Back-to-back: single-cycle ops accepted every clock, out_valid high every clock.
REQ-018 cero = (Y==0) for every opcode.
REQ-019 negativo = Y[N-1] for add/sub, 0 otherwise.
REQ-020 acarreo: add carry-out; sub borrow (A<B unsigned); shifts last bit shifted out (0 if shamt=0); multiply 1 if product upper N bits nonzero; logic 0.
REQ-021 desbordamiento: signed two's-complement overflow for add/sub, 0 otherwise.
REQ-022 Operands change during SHIFT/MUL have no effect on the in-flight result.

Reset
REQ-023 rst high: state IDLE, Y=0, all flags 0, out_valid=0, in_ready=1 (immediately, asynchronous).
REQ-024 rst during SHIFT/MUL aborts the operation; no out_valid pulse for it.
REQ-025 First request accepted on first rising edge after rst deasserts.

Configuration
REQ-026 Macro ALU_SEQ_MUL_EN: defined -> opcode 1010 multiply per REQ-015/020; undefined -> no MUL state or multiplier datapath, 1010 treated as A+B with latency 1.

Verification
REQ-027 N=8, 0100, A=0xFF, B=0x01 -> Y=0x00, cero=1, acarreo=1, desbordamiento=0, out_valid 1 cycle after accept.
REQ-028 N=8, 0101, A=0x80, B=0x01 -> Y=0x7F, desbordamiento=1, negativo=0, acarreo=0.
REQ-029 N=8, 1001, A=0x90, B=0x03 -> Y=0xF2, acarreo=0, in_ready low 3 cycles, out_valid 4 cycles after accept.
REQ-030 N=8 with ALU_SEQ_MUL_EN, 1010, A=0x10, B=0x11 -> Y=0x10, acarreo=1, out_valid 9 cycles after accept; without macro -> Y=0x21, latency 1.
REQ-031 rst asserted 2 cycles into 0110 shift with shamt=5 -> Y=0, flags 0, no out_valid, next request accepted normally.
REQ-032 in_valid held high during shift -> only one acceptance; ten back-to-back AND ops -> ten consecutive out_valid pulses.
